// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM states, a_ns encodings, majority helper.
// No logic of its own; imported by the slice, the top and the bench.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub; master = producer/consumer side, slave = block.
// Optional SERIAL_ADDSUB_OVF_EN adds the ovf result flag.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_ns;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf;

    modport master (output in_valid, a, b, a_ns, out_ready,
                    input  in_ready, out_valid, result, cout, ovf);
    modport slave  (input  in_valid, a, b, a_ns, out_ready,
                    output in_ready, out_valid, result, cout, ovf);
`else
    modport master (output in_valid, a, b, a_ns, out_ready,
                    input  in_ready, out_valid, result, cout);
    modport slave  (input  in_valid, a, b, a_ns, out_ready,
                    output in_ready, out_valid, result, cout);
`endif
endinterface

// File: rtl/serial_addsub_fas.sv
// One-bit full adder/subtractor slice (a_ns=1 add, 0 subtract with borrow).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module serial_addsub_fas
    import serial_addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);

    assign s = a ^ b ^ cin;

    // Borrow is the carry of the same slice with A inverted; B is never inverted.
    assign cout = (a_ns == OP_ADD) ? maj(a, b, cin) : maj(~a, b, cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract, LSB first through one slice; optional SERIAL_ADDSUB_OVF_EN adds ovf.
// Latency: WIDTH+1 clocks from acceptance edge to out_valid; one op per WIDTH+2 clocks.
// Backpressure: in_ready only in IDLE; DONE holds result/cout until out_ready.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    serial_addsub_if.slave bus
);

    state_t             state_q;
    state_t             state_d;
    logic               in_rdy;
    logic               out_vld;

    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic               carry_q;
    logic               op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_bit;

    logic               fas_s;
    logic               fas_c;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_vld = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.result    = res_sr;
    assign bus.cout      = carry_q;

    serial_addsub_fas u_fas (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .a_ns (op_q),
        .s    (fas_s),
        .cout (fas_c)
    );

    // Sum bits enter from the MSB side so after WIDTH shifts bit 0 lands in res_sr[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr    <= bus.a;
                        b_sr    <= bus.b;
                        op_q    <= bus.a_ns;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= {fas_s, res_sr[WIDTH-1:1]};
                    carry_q <= fas_c;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    // Operand MSBs are shifted out of a_sr/b_sr, so they are kept aside at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.in_valid) begin
                a_msb_q <= bus.a[WIDTH-1];
                b_msb_q <= bus.b[WIDTH-1];
                ovf_q   <= 1'b0;
            end else if (state_q == RUN && last_bit) begin
                if (op_q == OP_ADD) begin
                    ovf_q <= (a_msb_q == b_msb_q) && (fas_s != a_msb_q);
                end else begin
                    ovf_q <= (a_msb_q != b_msb_q) && (fas_s != a_msb_q);
                end
            end
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Randomised + directed bench for serial_addsub against an arithmetic reference model.
// Also checks ovf when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    localparam int WIDTH = 8;
    localparam int TMO   = 40;
    localparam int MODV  = 1 << WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #25 clk = ~clk;

    serial_addsub_if #(.WIDTH(WIDTH)) bus();

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // {cout, result} from plain integer arithmetic.
    function automatic logic [WIDTH:0] ref_calc(input int ua, input int ub, input logic op);
        int r;
        logic c;
        if (op == OP_ADD) begin
            r = ua + ub;
            c = (r >= MODV);
            r = r % MODV;
        end else begin
            c = (ua < ub);
            r = (ua - ub + MODV) % MODV;
        end
        return {c, WIDTH'(r)};
    endfunction

    function automatic logic ref_ovf(input int ua, input int ub, input logic op);
        int sa, sb, r;
        sa = (ua >= MODV / 2) ? ua - MODV : ua;
        sb = (ub >= MODV / 2) ? ub - MODV : ub;
        r  = (op == OP_ADD) ? sa + sb : sa - sb;
        return (r > MODV / 2 - 1) || (r < -(MODV / 2));
    endfunction

    task automatic do_op(input int ua, input int ub, input logic op,
                         input int hold, input bit poke, input string tag);
        logic [WIDTH:0] exp;
        int k;
        exp = ref_calc(ua, ub, op);
        @(negedge clk);
        bus.a         = WIDTH'(ua);
        bus.b         = WIDTH'(ub);
        bus.a_ns      = op;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        k = 0;
        while (!bus.in_ready && k < TMO) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "/accept"}, 32'(k < TMO), 1);
        // Acceptance happens at the next rising edge; afterwards scramble the inputs.
        @(negedge clk);
        k = 1;
        bus.in_valid = poke;
        bus.a        = ~WIDTH'(ua);
        bus.b        = WIDTH'(ua ^ ub ^ 8'h5a);
        bus.a_ns     = ~op;
        while (!bus.out_valid && k < TMO) begin
            if (k == 4) bus.in_valid = 1'b0;
            @(negedge clk);
            k++;
        end
        bus.in_valid = 1'b0;
        chk({tag, "/latency"}, k, WIDTH + 1);
        chk({tag, "/result"}, bus.result, exp[WIDTH-1:0]);
        chk({tag, "/cout"}, bus.cout, exp[WIDTH]);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk({tag, "/ovf"}, bus.ovf, ref_ovf(ua, ub, op));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hold_vld"}, bus.out_valid, 1);
            chk({tag, "/hold_res"}, bus.result, exp[WIDTH-1:0]);
            chk({tag, "/hold_rdy"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "/vld_drop"}, bus.out_valid, 0);
        chk({tag, "/rdy_back"}, bus.in_ready, 1);
        bus.out_ready = 1'b0;
    endtask

    int ta [7] = '{200, 100, 5, 7, 8'hff, 8'h00, 8'h80};
    int tb [7] = '{100, 100, 7, 5, 8'h01, 8'h01, 8'h01};
    bit top[7] = '{1,   1,   0, 0, 1,     0,     0};

    initial begin
        int spur;
        int got, last_t, gap;
        bit chg;
        logic [WIDTH:0] q[$];
        logic [WIDTH:0] e;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.a_ns      = 1'b0;

        @(negedge clk);
        chk("rst/in_ready", bus.in_ready, 1);
        chk("rst/out_valid", bus.out_valid, 0);
        chk("rst/result", bus.result, 0);
        chk("rst/cout", bus.cout, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("rst/ovf", bus.ovf, 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) do_op(ta[i], tb[i], top[i], 0, 1'b0, $sformatf("dir%0d", i));

        do_op(200, 100, 1'b1, 5, 1'b1, "hold_busy");

        for (int i = 0; i < 24; i++)
            do_op($urandom_range(0, MODV - 1), $urandom_range(0, MODV - 1), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));

        // Reset during the 4th RUN cycle.
        @(negedge clk);
        bus.a = 8'hAA; bus.b = 8'h55; bus.a_ns = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst/in_ready", bus.in_ready, 1);
        chk("midrst/out_valid", bus.out_valid, 0);
        chk("midrst/result", bus.result, 0);
        chk("midrst/cout", bus.cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        spur = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) spur++;
        end
        chk("midrst/spurious", spur, 0);
        do_op(3, 4, 1'b1, 0, 1'b0, "after_rst");

        // Back-to-back with out_ready tied high.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a = WIDTH'($urandom_range(0, MODV - 1));
        bus.b = WIDTH'($urandom_range(0, MODV - 1));
        bus.a_ns = 1'($urandom_range(0, 1));
        got = 0; last_t = -1; chg = 1'b0;
        for (int t = 0; t < 100 && got < 5; t++) begin
            if (bus.out_valid) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                chk("b2b/result", bus.result, e[WIDTH-1:0]);
                chk("b2b/cout", bus.cout, e[WIDTH]);
                if (last_t >= 0) begin
                    gap = t - last_t;
                    chk("b2b/period", gap, WIDTH + 2);
                end
                last_t = t;
                got++;
            end
            if (chg) begin
                bus.a = WIDTH'($urandom_range(0, MODV - 1));
                bus.b = WIDTH'($urandom_range(0, MODV - 1));
                bus.a_ns = 1'($urandom_range(0, 1));
                chg = 1'b0;
            end
            if (bus.in_ready) begin
                q.push_back(ref_calc(int'(bus.a), int'(bus.b), bus.a_ns));
                chg = 1'b1;
            end
            @(negedge clk);
        end
        chk("b2b/count", got, 5);
        bus.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
